// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: issues each data-memory access once and holds while memory stalls.
// Optional STALL_COUNT_EN adds a saturating stall_cycles counter output.
//   state  | meaning
//   IDLE   | no memory access outstanding
//   ISSUE  | access latched, C_DMemEn high this cycle only
//   WAIT   | enable dropped, memory still stalling
module ex_mem_latch #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_ALUOut,
    input  logic [DATA_W-1:0] ex_ReadData2,
    input  logic              ex_DMemEn,
    input  logic              ex_DMemWrite,
    input  logic              ex_DMemDump,
    input  logic              ex_RegWrite,
    input  logic [REG_W-1:0]  ex_WriteReg,
    input  logic              ex_valid,
    input  logic              flush,
    input  logic              Dmem_Stall,
    input  logic              err,
    output logic [DATA_W-1:0] ALUOut,
    output logic [DATA_W-1:0] ReadData2,
    output logic              C_DMemEn,
    output logic              C_DMemWrite,
    output logic              C_DMemDump,
    output logic              RegWrite,
    output logic [REG_W-1:0]  WriteReg,
    output logic              valid_out,
    output logic              stall_up,
    output logic              err_sticky
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  aluout_q, aluout_d;
    logic [DATA_W-1:0]  readdata2_q, readdata2_d;
    logic               dmemwrite_q, dmemwrite_d;
    logic               dmemdump_q, dmemdump_d;
    logic               regwrite_q, regwrite_d;
    logic [REG_W-1:0]   writereg_q, writereg_d;
    logic               valid_q, valid_d;
    logic               pending_flush_q, pending_flush_d;
    logic               err_sticky_q, err_sticky_d;
    logic               stall_w;
    logic               take_w;

    always_comb begin
        stall_w         = (state_q != S_IDLE) && Dmem_Stall;
        take_w          = ex_valid & ~flush & ~pending_flush_q;
        state_d         = state_q;
        aluout_d        = aluout_q;
        readdata2_d     = readdata2_q;
        dmemwrite_d     = dmemwrite_q;
        dmemdump_d      = dmemdump_q;
        regwrite_d      = regwrite_q;
        writereg_d      = writereg_q;
        valid_d         = valid_q;
        pending_flush_d = pending_flush_q;
        err_sticky_d    = err_sticky_q | (err & (state_q != S_IDLE));

        if (!stall_w) begin
            aluout_d        = ex_ALUOut;
            readdata2_d     = ex_ReadData2;
            writereg_d      = ex_WriteReg;
            // squashed or empty slots keep their data but lose every enable
            dmemwrite_d     = ex_DMemWrite & ex_DMemEn & take_w;
            dmemdump_d      = ex_DMemDump & take_w;
            regwrite_d      = ex_RegWrite & take_w;
            valid_d         = take_w;
            pending_flush_d = 1'b0;
            state_d         = (take_w && ex_DMemEn) ? S_ISSUE : S_IDLE;
        end else begin
            // an in-flight access is never aborted; remember the flush instead
            pending_flush_d = pending_flush_q | flush;
            state_d         = S_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            aluout_q        <= '0;
            readdata2_q     <= '0;
            dmemwrite_q     <= 1'b0;
            dmemdump_q      <= 1'b0;
            regwrite_q      <= 1'b0;
            writereg_q      <= '0;
            valid_q         <= 1'b0;
            pending_flush_q <= 1'b0;
            err_sticky_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            aluout_q        <= aluout_d;
            readdata2_q     <= readdata2_d;
            dmemwrite_q     <= dmemwrite_d;
            dmemdump_q      <= dmemdump_d;
            regwrite_q      <= regwrite_d;
            writereg_q      <= writereg_d;
            valid_q         <= valid_d;
            pending_flush_q <= pending_flush_d;
            err_sticky_q    <= err_sticky_d;
        end
    end

    assign ALUOut      = aluout_q;
    assign ReadData2   = readdata2_q;
    assign C_DMemEn    = (state_q == S_ISSUE);
    assign C_DMemWrite = (state_q == S_ISSUE) & dmemwrite_q;
    assign C_DMemDump  = dmemdump_q;
    assign RegWrite    = regwrite_q;
    assign WriteReg    = writereg_q;
    assign valid_out   = valid_q & ~stall_w;
    assign stall_up    = stall_w;
    assign err_sticky  = err_sticky_q;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: directed vectors, memory-enable and completion monitors.
module tb_ex_mem_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ex_ALUOut, ex_ReadData2;
    logic        ex_DMemEn, ex_DMemWrite, ex_DMemDump, ex_RegWrite;
    logic [2:0]  ex_WriteReg;
    logic        ex_valid, flush, Dmem_Stall, err;
    logic [15:0] ALUOut, ReadData2;
    logic        C_DMemEn, C_DMemWrite, C_DMemDump, RegWrite;
    logic [2:0]  WriteReg;
    logic        valid_out, stall_up, err_sticky;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    ex_mem_latch #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .rst(rst),
        .ex_ALUOut(ex_ALUOut), .ex_ReadData2(ex_ReadData2),
        .ex_DMemEn(ex_DMemEn), .ex_DMemWrite(ex_DMemWrite),
        .ex_DMemDump(ex_DMemDump), .ex_RegWrite(ex_RegWrite),
        .ex_WriteReg(ex_WriteReg), .ex_valid(ex_valid),
        .flush(flush), .Dmem_Stall(Dmem_Stall), .err(err),
        .ALUOut(ALUOut), .ReadData2(ReadData2),
        .C_DMemEn(C_DMemEn), .C_DMemWrite(C_DMemWrite),
        .C_DMemDump(C_DMemDump), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .valid_out(valid_out),
        .stall_up(stall_up), .err_sticky(err_sticky)
`ifdef STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rd2;
        logic        rw;
        logic [2:0]  wreg;
        logic        dump;
    } comp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] data;
    } mem_t;

    comp_t comp_q[$];
    mem_t  mem_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] alu, input logic [15:0] rd2,
                         input logic en, input logic wr, input logic dump,
                         input logic rw, input logic [2:0] wreg,
                         input logic push_comp, input logic push_mem);
        comp_t c;
        mem_t  m;
        ex_ALUOut    = alu;
        ex_ReadData2 = rd2;
        ex_DMemEn    = en;
        ex_DMemWrite = wr;
        ex_DMemDump  = dump;
        ex_RegWrite  = rw;
        ex_WriteReg  = wreg;
        ex_valid     = 1'b1;
        if (push_comp) begin
            c = '{alu: alu, rd2: rd2, rw: rw, wreg: wreg, dump: dump};
            comp_q.push_back(c);
        end
        if (push_mem) begin
            m = '{addr: alu, wr: wr, data: rd2};
            mem_q.push_back(m);
        end
    endtask

    task automatic bubble();
        ex_ALUOut    = 16'h0;
        ex_ReadData2 = 16'h0;
        ex_DMemEn    = 1'b0;
        ex_DMemWrite = 1'b0;
        ex_DMemDump  = 1'b0;
        ex_RegWrite  = 1'b0;
        ex_WriteReg  = 3'd0;
        ex_valid     = 1'b0;
    endtask

    // memory-side monitor: every enable pulse must match one issued access
    always @(negedge clk) begin
        if (rst === 1'b1 && C_DMemEn === 1'b1) begin
            mem_t e;
            if (mem_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_unexpected: got enable addr %0h want no access", ALUOut);
            end else begin
                e = mem_q.pop_front();
                chk("mem_addr", {16'h0, ALUOut}, {16'h0, e.addr});
                chk("mem_write", {31'h0, C_DMemWrite}, {31'h0, e.wr});
                if (e.wr) chk("mem_data", {16'h0, ReadData2}, {16'h0, e.data});
            end
        end
    end

    // completion monitor: every valid_out must match one expected result
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_out === 1'b1) begin
            comp_t e;
            if (comp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL comp_unexpected: got valid_out alu %0h want none", ALUOut);
            end else begin
                e = comp_q.pop_front();
                chk("comp_alu", {16'h0, ALUOut}, {16'h0, e.alu});
                chk("comp_rd2", {16'h0, ReadData2}, {16'h0, e.rd2});
                chk("comp_rw", {31'h0, RegWrite}, {31'h0, e.rw});
                chk("comp_wreg", {29'h0, WriteReg}, {29'h0, e.wreg});
                chk("comp_dump", {31'h0, C_DMemDump}, {31'h0, e.dump});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        Dmem_Stall = 1'b0;
        err = 1'b0;
        bubble();
        #3;
        chk("rst_alu", {16'h0, ALUOut}, 32'h0);
        chk("rst_en", {31'h0, C_DMemEn}, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_rw", {31'h0, RegWrite}, 32'h0);
        chk("rst_err", {31'h0, err_sticky}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // err while idle must not latch
        err = 1'b1;
        tick();
        err = 1'b0;
        @(negedge clk);
        chk("err_idle", {31'h0, err_sticky}, 32'h0);
        tick();

        // load hit
        drive(16'h0010, 16'h1111, 1, 0, 0, 1, 3'd1, 1, 1);
        tick();
        bubble();
        @(negedge clk);
        chk("t1_en", {31'h0, C_DMemEn}, 32'h1);
        chk("t1_alu", {16'h0, ALUOut}, 32'h0010);
        chk("t1_valid", {31'h0, valid_out}, 32'h1);
        chk("t1_stall", {31'h0, stall_up}, 32'h0);
        tick();
        @(negedge clk);
        chk("t1_en_once", {31'h0, C_DMemEn}, 32'h0);
        tick();

        // store with four stalled cycles
        drive(16'h0020, 16'hBEEF, 1, 1, 0, 0, 3'd0, 1, 1);
        Dmem_Stall = 1'b1;
        tick();
        bubble();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_stall", {31'h0, stall_up}, 32'h1);
            chk("t2_alu_frozen", {16'h0, ALUOut}, 32'h0020);
            chk("t2_rd2_frozen", {16'h0, ReadData2}, 32'hBEEF);
            chk("t2_valid_low", {31'h0, valid_out}, 32'h0);
            if (i > 0) chk("t2_en_low", {31'h0, C_DMemEn}, 32'h0);
            tick();
        end
        Dmem_Stall = 1'b0;
        @(negedge clk);
        chk("t2_valid5", {31'h0, valid_out}, 32'h1);
        chk("t2_stall5", {31'h0, stall_up}, 32'h0);
        chk("t2_en5", {31'h0, C_DMemEn}, 32'h0);
        tick();

        // ALU op with dump
        drive(16'h00AB, 16'h0000, 0, 0, 1, 1, 3'd5, 1, 0);
        tick();
        bubble();
        @(negedge clk);
        chk("t3_rw", {31'h0, RegWrite}, 32'h1);
        chk("t3_wreg", {29'h0, WriteReg}, 32'h5);
        chk("t3_valid", {31'h0, valid_out}, 32'h1);
        chk("t3_en", {31'h0, C_DMemEn}, 32'h0);
        chk("t3_dump", {31'h0, C_DMemDump}, 32'h1);
        tick();

        // flush on the capture edge squashes a store
        drive(16'h0033, 16'h5555, 1, 1, 0, 1, 3'd6, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bubble();
        @(negedge clk);
        chk("fl_valid", {31'h0, valid_out}, 32'h0);
        chk("fl_rw", {31'h0, RegWrite}, 32'h0);
        chk("fl_en", {31'h0, C_DMemEn}, 32'h0);
        chk("fl_wr", {31'h0, C_DMemWrite}, 32'h0);
        tick();

        // flush during WAIT of a load miss
        drive(16'h0030, 16'h2222, 1, 0, 0, 1, 3'd3, 1, 1);
        Dmem_Stall = 1'b1;
        tick();
        drive(16'h0040, 16'h0000, 0, 0, 0, 1, 3'd2, 0, 0);
        @(negedge clk);
        chk("t4_stall", {31'h0, stall_up}, 32'h1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_en_low", {31'h0, C_DMemEn}, 32'h0);
        chk("t4_stall3", {31'h0, stall_up}, 32'h1);
        tick();
        Dmem_Stall = 1'b0;
        @(negedge clk);
        chk("t4_done", {31'h0, valid_out}, 32'h1);
        chk("t4_alu", {16'h0, ALUOut}, 32'h0030);
        tick();
        drive(16'h0050, 16'h0000, 0, 0, 0, 1, 3'd4, 1, 0);
        @(negedge clk);
        chk("t4_sq_valid", {31'h0, valid_out}, 32'h0);
        chk("t4_sq_rw", {31'h0, RegWrite}, 32'h0);
        chk("t4_sq_alu", {16'h0, ALUOut}, 32'h0040);
        tick();
        bubble();
        @(negedge clk);
        chk("t4_next_valid", {31'h0, valid_out}, 32'h1);
        chk("t4_next_wreg", {29'h0, WriteReg}, 32'h4);
        tick();

        // err during WAIT is sticky
        drive(16'h0060, 16'h0000, 1, 0, 0, 1, 3'd7, 1, 1);
        Dmem_Stall = 1'b1;
        tick();
        bubble();
        tick();
        err = 1'b1;
        tick();
        err = 1'b0;
        @(negedge clk);
        chk("t5_err", {31'h0, err_sticky}, 32'h1);
        tick();
        Dmem_Stall = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'h0, valid_out}, 32'h1);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t5_err_held", {31'h0, err_sticky}, 32'h1);
        tick();

        // reset in the middle of a stalled store
        drive(16'h0070, 16'h3333, 1, 1, 0, 0, 3'd0, 0, 1);
        Dmem_Stall = 1'b1;
        tick();
        bubble();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_alu", {16'h0, ALUOut}, 32'h0);
        chk("t6_rd2", {16'h0, ReadData2}, 32'h0);
        chk("t6_en", {31'h0, C_DMemEn}, 32'h0);
        chk("t6_wr", {31'h0, C_DMemWrite}, 32'h0);
        chk("t6_valid", {31'h0, valid_out}, 32'h0);
        chk("t6_stall", {31'h0, stall_up}, 32'h0);
        chk("t6_err", {31'h0, err_sticky}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_no_en", {31'h0, C_DMemEn}, 32'h0);
        tick();
        Dmem_Stall = 1'b0;
        drive(16'h0080, 16'h4444, 1, 0, 0, 1, 3'd1, 1, 1);
        tick();
        bubble();
        @(negedge clk);
        chk("t6_load_en", {31'h0, C_DMemEn}, 32'h1);
        chk("t6_load_alu", {16'h0, ALUOut}, 32'h0080);
        chk("t6_load_valid", {31'h0, valid_out}, 32'h1);
        tick();
        tick();

        @(negedge clk);
        chk("mem_q_empty", mem_q.size(), 32'h0);
        chk("comp_q_empty", comp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
